// File: rtl/me_req_sequencer.sv
// me_req_sequencer: initiator side of the motion-estimation req/ack handshake.
// Walks the frame in raster order; per macroblock it pulses mb_load, waits for
// the loader, raises req to the full-search core, captures the result on ack,
// waits for ack to drop and then offers one record on a valid/ready stream.
// A watchdog aborts the frame if ack never arrives.
//
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   start                      frame start (sampled only in IDLE)
//   busy, frame_done, err      frame status (err is sticky until next start)
//   mb_x, mb_y, mb_load        current block index and loader trigger pulse
//   mb_load_done               loader completion
//   req, ack, min_sad, min_mvec  handshake with the search core
//   res_*                      result record stream (valid/ready)
module me_req_sequencer #(
  parameter int unsigned SAD_WIDTH      = 16,
  parameter int unsigned MVEC_WIDTH     = 12,
  parameter int unsigned MB_COLS        = 4,
  parameter int unsigned MB_ROWS        = 4,
  parameter int unsigned IDX_WIDTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 8192,
  parameter int unsigned TO_WIDTH       = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err,
  output logic [IDX_WIDTH-1:0]  mb_x,
  output logic [IDX_WIDTH-1:0]  mb_y,
  output logic                  mb_load,
  input  logic                  mb_load_done,
  output logic                  req,
  input  logic                  ack,
  input  logic [SAD_WIDTH-1:0]  min_sad,
  input  logic [MVEC_WIDTH-1:0] min_mvec,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [SAD_WIDTH-1:0]  res_sad,
  output logic [MVEC_WIDTH-1:0] res_mvec,
  output logic [IDX_WIDTH-1:0]  res_mb_x,
  output logic [IDX_WIDTH-1:0]  res_mb_y,
  output logic                  res_last
);

  localparam logic [IDX_WIDTH-1:0] LAST_X  = IDX_WIDTH'(MB_COLS - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_Y  = IDX_WIDTH'(MB_ROWS - 1);
  localparam logic [TO_WIDTH-1:0]  TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_REQ,
    S_LOAD_WAIT,
    S_SEARCH,
    S_RELEASE,
    S_OUTPUT,
    S_ABORT
  } state_t;

  state_t                state, state_d;
  logic [TO_WIDTH-1:0]   to_cnt, to_cnt_d;
  logic                  busy_d, frame_done_d, err_d, mb_load_d, req_d;
  logic [IDX_WIDTH-1:0]  mb_x_d, mb_y_d, res_mb_x_d, res_mb_y_d;
  logic                  res_valid_d, res_last_d;
  logic [SAD_WIDTH-1:0]  res_sad_d;
  logic [MVEC_WIDTH-1:0] res_mvec_d;

  // State and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      to_cnt     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      mb_x       <= '0;
      mb_y       <= '0;
      mb_load    <= 1'b0;
      req        <= 1'b0;
      res_valid  <= 1'b0;
      res_sad    <= '1;
      res_mvec   <= '0;
      res_mb_x   <= '0;
      res_mb_y   <= '0;
      res_last   <= 1'b0;
    end else begin
      state      <= state_d;
      to_cnt     <= to_cnt_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      err        <= err_d;
      mb_x       <= mb_x_d;
      mb_y       <= mb_y_d;
      mb_load    <= mb_load_d;
      req        <= req_d;
      res_valid  <= res_valid_d;
      res_sad    <= res_sad_d;
      res_mvec   <= res_mvec_d;
      res_mb_x   <= res_mb_x_d;
      res_mb_y   <= res_mb_y_d;
      res_last   <= res_last_d;
    end
  end

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_d      = state;
    to_cnt_d     = to_cnt;
    busy_d       = busy;
    frame_done_d = 1'b0;
    err_d        = err;
    mb_x_d       = mb_x;
    mb_y_d       = mb_y;
    mb_load_d    = 1'b0;
    req_d        = req;
    res_valid_d  = res_valid;
    res_sad_d    = res_sad;
    res_mvec_d   = res_mvec;
    res_mb_x_d   = res_mb_x;
    res_mb_y_d   = res_mb_y;
    res_last_d   = res_last;

    case (state)
      S_IDLE: begin
        if (start) begin
          busy_d    = 1'b1;
          err_d     = 1'b0;
          mb_x_d    = '0;
          mb_y_d    = '0;
          mb_load_d = 1'b1;
          state_d   = S_LOAD_REQ;
        end
      end

      // mb_load is high for exactly the cycle spent here.
      S_LOAD_REQ: state_d = S_LOAD_WAIT;

      S_LOAD_WAIT: begin
        if (mb_load_done) begin
          req_d    = 1'b1;
          to_cnt_d = '0;
          state_d  = S_SEARCH;
        end
      end

      // ack is checked before the watchdog so a late-but-valid result is kept.
      S_SEARCH: begin
        if (ack) begin
          res_sad_d  = min_sad;
          res_mvec_d = min_mvec;
          res_mb_x_d = mb_x;
          res_mb_y_d = mb_y;
          res_last_d = (mb_x == LAST_X) && (mb_y == LAST_Y);
          req_d      = 1'b0;
          state_d    = S_RELEASE;
        end else if (to_cnt == TO_LAST) begin
          req_d        = 1'b0;
          err_d        = 1'b1;
          frame_done_d = 1'b1;
          state_d      = S_ABORT;
        end else begin
          to_cnt_d = to_cnt + TO_WIDTH'(1);
        end
      end

      // Hold off until the core drops ack so the next req starts a clean handshake.
      S_RELEASE: begin
        if (!ack) begin
          res_valid_d = 1'b1;
          state_d     = S_OUTPUT;
        end
      end

      S_OUTPUT: begin
        if (res_valid && res_ready) begin
          res_valid_d = 1'b0;
          if (res_last) begin
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            if (mb_x == LAST_X) begin
              mb_x_d = '0;
              mb_y_d = mb_y + IDX_WIDTH'(1);
            end else begin
              mb_x_d = mb_x + IDX_WIDTH'(1);
            end
            mb_load_d = 1'b1;
            state_d   = S_LOAD_REQ;
          end
        end
      end

      // frame_done is already high for this cycle; drop busy and go idle.
      S_ABORT: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_me_req_sequencer.sv
// Directed bench for me_req_sequencer with a 2x2 frame and a 16-cycle watchdog.
// Behavioural loader and core models respond on the DUT handshakes; a negedge
// monitor collects records and timing, the main sequence checks them.
module tb_me_req_sequencer;

  localparam int unsigned SW = 16;
  localparam int unsigned MW = 12;
  localparam int unsigned IW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, frame_done, err, mb_load, req, res_valid, res_last;
  logic [IW-1:0] mb_x, mb_y, res_mb_x, res_mb_y;
  logic          mb_load_done = 1'b0;
  logic          ack = 1'b0;
  logic [SW-1:0] min_sad = 16'hDEAD;
  logic [MW-1:0] min_mvec = 12'hBAD;
  logic          res_ready = 1'b1;
  logic [SW-1:0] res_sad;
  logic [MW-1:0] res_mvec;

  me_req_sequencer #(
    .SAD_WIDTH(SW), .MVEC_WIDTH(MW), .MB_COLS(2), .MB_ROWS(2),
    .IDX_WIDTH(IW), .TIMEOUT_CYCLES(16), .TO_WIDTH(14)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .frame_done(frame_done), .err(err), .mb_x(mb_x), .mb_y(mb_y),
    .mb_load(mb_load), .mb_load_done(mb_load_done), .req(req), .ack(ack),
    .min_sad(min_sad), .min_mvec(min_mvec), .res_valid(res_valid),
    .res_ready(res_ready), .res_sad(res_sad), .res_mvec(res_mvec),
    .res_mb_x(res_mb_x), .res_mb_y(res_mb_y), .res_last(res_last)
  );

  always #5 clk = ~clk;

  logic [SW-1:0] sad_tab  [4] = '{16'h0123, 16'h0456, 16'h0789, 16'h0ABC};
  logic [MW-1:0] mvec_tab [4] = '{12'h041, 12'h082, 12'h0C3, 12'h104};

  // Core model controls
  int core_delay = 10;
  int core_en    = 1;
  int ack_extra  = 0;
  int core_idx   = 0;
  // Ready stall control: hold ready low 5 cycles on the stall_idx-th record (1-based)
  int stall_idx  = 0;
  int vidx       = 0;

  // Monitor results
  logic [SW-1:0] rec_sad  [8];
  logic [MW-1:0] rec_mvec [8];
  logic [IW-1:0] rec_x    [8];
  logic [IW-1:0] rec_y    [8];
  logic          rec_last [8];
  int n_rec, n_done, valid_cycles, stall_cycles, stab_viol, load_viol, req_viol;
  int run, last_run, ncyc, ack_fall_t, req_fall_t, valid_rise_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Loader: completes a few cycles after each mb_load pulse
  initial begin
    forever begin
      @(posedge clk); #1;
      if (mb_load) begin
        repeat (2) begin @(posedge clk); #1; end
        mb_load_done = 1'b1;
        @(posedge clk); #1;
        mb_load_done = 1'b0;
      end
    end
  end

  // Core: ack after core_delay cycles of req, hold ack ack_extra cycles past req fall
  initial begin
    int phase, cnt, hold;
    phase = 0; cnt = 0; hold = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        phase = 0; cnt = 0; hold = 0;
        ack = 1'b0; min_sad = 16'hDEAD; min_mvec = 12'hBAD;
      end else if (phase == 0) begin
        if (req) cnt++; else cnt = 0;
        if (req && core_en != 0 && cnt == core_delay) begin
          ack      = 1'b1;
          min_sad  = sad_tab[core_idx % 4];
          min_mvec = mvec_tab[core_idx % 4];
          core_idx++;
          phase = 1; hold = 0;
        end
      end else if (!req) begin
        if (hold < ack_extra) hold++;
        else begin
          ack = 1'b0; min_sad = 16'hDEAD; min_mvec = 12'hBAD;
          phase = 0; cnt = 0;
        end
      end
    end
  end

  // Downstream ready driver
  initial begin
    int  stall_left;
    logic prev_v;
    stall_left = 0; prev_v = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) res_ready = 1'b1;
      end else if (res_valid && !prev_v) begin
        vidx++;
        if (vidx == stall_idx) begin
          res_ready  = 1'b0;
          stall_left = 5;
        end
      end
      prev_v = res_valid;
    end
  end

  // Monitor on the falling edge
  initial begin
    logic prev_req, prev_ack, prev_valid, prev_hold;
    logic [SW-1:0] h_sad;
    logic [MW-1:0] h_mvec;
    logic [IW-1:0] h_x, h_y;
    logic h_last;
    prev_req = 0; prev_ack = 0; prev_valid = 0; prev_hold = 0;
    h_sad = '0; h_mvec = '0; h_x = '0; h_y = '0; h_last = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 0; prev_ack = 0; prev_valid = 0; prev_hold = 0; run = 0;
      end else begin
        if (res_valid && res_ready) begin
          if (n_rec < 8) begin
            rec_sad[n_rec] = res_sad;   rec_mvec[n_rec] = res_mvec;
            rec_x[n_rec]   = res_mb_x;  rec_y[n_rec]    = res_mb_y;
            rec_last[n_rec] = res_last;
          end
          n_rec++;
        end
        if (res_valid) valid_cycles++;
        if (res_valid && !res_ready) stall_cycles++;
        if (prev_hold && (!res_valid || res_sad != h_sad || res_mvec != h_mvec ||
                          res_mb_x != h_x || res_mb_y != h_y || res_last != h_last))
          stab_viol++;
        prev_hold = res_valid && !res_ready;
        h_sad = res_sad; h_mvec = res_mvec; h_x = res_mb_x; h_y = res_mb_y; h_last = res_last;
        if (mb_load && res_valid) load_viol++;
        if (frame_done) n_done++;
        if (req) run++;
        else begin
          if (prev_req) last_run = run;
          run = 0;
        end
        if (req && !prev_req && prev_ack) req_viol++;
        if (!ack && prev_ack) ack_fall_t = ncyc;
        if (!req && prev_req) req_fall_t = ncyc;
        if (res_valid && !prev_valid) valid_rise_t = ncyc;
        prev_req = req; prev_ack = ack; prev_valid = res_valid;
      end
      ncyc++;
    end
  end

  task automatic clear_mon();
    n_rec = 0; n_done = 0; valid_cycles = 0; stall_cycles = 0;
    stab_viol = 0; load_viol = 0; req_viol = 0; last_run = 0;
    core_idx = 0; vidx = 0;
  endtask

  task automatic start_frame(input string name);
    clear_mon();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check_eq({name, "_busy_after_start"}, 32'(busy), 32'd1);
    check_eq({name, "_err_after_start"}, 32'(err), 32'd0);
  endtask

  task automatic wait_done(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (n_done >= 1 && !busy) begin done = 1'b1; break; end
    end
    check_eq({name, "_frame_finished"}, 32'(done), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string name);
    check_eq({name, "_records"}, 32'(n_rec), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s_sad%0d", name, i),  32'(rec_sad[i]),  32'(sad_tab[i]));
      check_eq($sformatf("%s_mvec%0d", name, i), 32'(rec_mvec[i]), 32'(mvec_tab[i]));
      check_eq($sformatf("%s_x%0d", name, i),    32'(rec_x[i]),    32'(i % 2));
      check_eq($sformatf("%s_y%0d", name, i),    32'(rec_y[i]),    32'(i / 2));
      check_eq($sformatf("%s_last%0d", name, i), 32'(rec_last[i]), 32'(i == 3));
    end
    check_eq({name, "_frame_done_count"}, 32'(n_done), 32'd1);
    check_eq({name, "_err"}, 32'(err), 32'd0);
    check_eq({name, "_busy_end"}, 32'(busy), 32'd0);
    check_eq({name, "_stability"}, 32'(stab_viol), 32'd0);
    check_eq({name, "_load_during_valid"}, 32'(load_viol), 32'd0);
    check_eq({name, "_req_before_ack_low"}, 32'(req_viol), 32'd0);
    check_eq({name, "_ack_fall_to_valid"}, 32'(valid_rise_t - ack_fall_t), 32'd1);
  endtask

  initial begin
    clear_mon();
    ncyc = 0; run = 0; ack_fall_t = 0; req_fall_t = 0; valid_rise_t = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_req", 32'(req), 32'd0);
    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_res_sad", 32'(res_sad), 32'hFFFF);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_mb_load", 32'(mb_load), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_mb_xy", 32'({mb_x, mb_y}), 32'd0);
    rst_n = 1'b1;

    // 1: plain frame
    start_frame("t1");
    wait_done("t1");
    check_frame("t1");
    check_eq("t1_stall_cycles", 32'(stall_cycles), 32'd0);

    // 2: ready stall on record 2, plus a start pulse while busy (ignored)
    stall_idx = 2;
    start_frame("t2");
    repeat (20) @(posedge clk);
    #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done("t2");
    check_frame("t2");
    check_eq("t2_stall_cycles", 32'(stall_cycles), 32'd5);
    stall_idx = 0;

    // 3: core never acks -> watchdog abort, then a restart clears err
    core_en = 0;
    start_frame("t3");
    wait_done("t3");
    check_eq("t3_req_high_cycles", 32'(last_run), 32'd16);
    check_eq("t3_err", 32'(err), 32'd1);
    check_eq("t3_frame_done_count", 32'(n_done), 32'd1);
    check_eq("t3_no_valid", 32'(valid_cycles), 32'd0);
    check_eq("t3_res_sad_untouched", 32'(res_sad), 32'h0ABC);
    core_en = 1;
    start_frame("t3b");
    wait_done("t3b");
    check_frame("t3b");

    // 4: ack on the terminal-count cycle wins over the watchdog
    core_delay = 16;
    start_frame("t4");
    wait_done("t4");
    check_frame("t4");
    check_eq("t4_req_high_cycles", 32'(last_run), 32'd16);
    core_delay = 10;

    // 5: ack held 4 cycles after req falls
    ack_extra = 4;
    start_frame("t5");
    wait_done("t5");
    check_frame("t5");
    check_eq("t5_req_fall_to_valid", 32'(valid_rise_t - req_fall_t), 32'd5);
    ack_extra = 0;

    // 6: async reset mid-search, then a fresh frame from (0,0)
    start_frame("t6");
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk); #1;
        if (req) begin seen = 1'b1; break; end
      end
      check_eq("t6_req_seen", 32'(seen), 32'd1);
    end
    repeat (3) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    check_eq("t6_rst_req", 32'(req), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_valid", 32'(res_valid), 32'd0);
    check_eq("t6_rst_res_sad", 32'(res_sad), 32'hFFFF);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("t6_idle_busy", 32'(busy), 32'd0);
    start_frame("t6b");
    wait_done("t6b");
    check_frame("t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
